// File: rtl/karpentium_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | karpentium_pkg                                                              |
// | Shared widths, memory depth and loader state encoding.                      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package karpentium_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

endpackage : karpentium_pkg
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loader_checksum                                                             |
// | Modulo-2^DATA_W accumulator with clear, add-enable and equality compare.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module loader_checksum #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              match
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + add_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == cmp_data);

endmodule : loader_checksum
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader                                                              |
// | Streams host words into program memory from address 0 while holding the    |
// | CPU in clear. Optional trailing checksum: KARP_LOADER_CHECKSUM_EN.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module program_loader
  import karpentium_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              mem_we_q, mem_we_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              xfer;

  assign xfer = in_valid & in_ready_q;

`ifdef KARP_LOADER_CHECKSUM_EN
  logic csum_clear;
  logic csum_add;
  logic csum_match;

  assign csum_clear = (state_q == ST_HDR);
  assign csum_add   = xfer & (state_q == ST_LOAD);

  loader_checksum #(
    .DATA_W (DATA_W)
  ) u_checksum (
    .clk      (clk),
    .clr      (clr),
    .clear    (csum_clear),
    .add_en   (csum_add),
    .add_data (in_data),
    .cmp_data (in_data),
    .match    (csum_match)
  );
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    mem_we_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (xfer) begin
          len_d = in_data[ADDR_W:0];
          if ((len_d == '0) || (len_d > MAX_LEN)) begin
            state_d = ST_ERR;
          end else begin
            ptr_d   = '0;
            count_d = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          addr_out_d = ptr_q;
          data_out_d = in_data;
          mem_we_d   = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          count_d    = count_q + 1'b1;
          if (count_d == len_q) begin
`ifdef KARP_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef KARP_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        // Checksum word is consumed here and never reaches memory.
        if (xfer) state_d = csum_match ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (start) state_d = ST_HDR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    in_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
    cpu_hold_d = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      mem_we_q   <= 1'b0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      mem_we_q   <= mem_we_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign addr_out = addr_out_q;
  assign data_out = data_out_q;
  assign mem_we   = mem_we_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_program_loader                                                           |
// | Self-checking bench: per-cycle reference model plus directed literals.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_program_loader;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE = 0;
  localparam int P_HDR  = 1;
  localparam int P_LOAD = 2;
  localparam int P_CSUM = 3;
  localparam int P_DONE = 4;
  localparam int P_ERR  = 5;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          mem_we;
  logic          cpu_hold;
  logic          done;
  logic          error;

  program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr_out (addr_out),
    .data_out (data_out),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session phase, expected write, running sum.
  int            m_phase = P_IDLE;
  int            m_len   = 0;
  int            m_cnt   = 0;
  logic [DW-1:0] m_sum   = '0;
  bit            m_we    = 1'b0;
  bit            m_rst   = 1'b0;
  bit            m_xfer;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  always @(posedge clk) begin
    m_xfer = in_valid && (m_phase == P_HDR || m_phase == P_LOAD || m_phase == P_CSUM);
    m_we   = 1'b0;
    m_rst  = 1'b0;
    if (clr) begin
      m_phase = P_IDLE;
      m_rst   = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: if (start) m_phase = P_HDR;
        P_ERR:  if (start) m_phase = P_HDR;
        P_DONE: m_phase = P_IDLE;
        P_HDR: if (m_xfer) begin
          m_len = int'(in_data[AW:0]);
          if (m_len == 0 || m_len > DEPTH) m_phase = P_ERR;
          else begin
            m_cnt   = 0;
            m_sum   = '0;
            m_phase = P_LOAD;
          end
        end
        P_LOAD: if (m_xfer) begin
          m_we   = 1'b1;
          m_addr = AW'(m_cnt % DEPTH);
          m_data = in_data;
          m_sum  = m_sum + in_data;
          m_cnt  = m_cnt + 1;
`ifdef KARP_LOADER_CHECKSUM_EN
          if (m_cnt == m_len) m_phase = P_CSUM;
`else
          if (m_cnt == m_len) m_phase = P_DONE;
`endif
        end
        P_CSUM: if (m_xfer) m_phase = (in_data == m_sum) ? P_DONE : P_ERR;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  logic [AW-1:0] wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (m_phase == P_HDR || m_phase == P_LOAD || m_phase == P_CSUM));
      check("cpu_hold", cpu_hold, (m_phase != P_IDLE));
      check("done", done, (m_phase == P_DONE));
      check("error", error, (m_phase == P_ERR));
      check("mem_we", mem_we, m_we);
      if (m_we) begin
        check("addr_out", addr_out, m_addr);
        check("data_out", data_out, m_data);
      end
      if (m_rst) begin
        check("rst_addr_out", addr_out, 0);
        check("rst_data_out", data_out, 0);
      end
      if (mem_we === 1'b1) begin
        wlog_a.push_back(addr_out);
        wlog_d.push_back(data_out);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
    done_cnt = 0;
  endtask

  task automatic check_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check("wlog_has_entry", (wlog_a.size() > i), 1);
    if (wlog_a.size() > i) begin
      check("wlog_addr", wlog_a[i], a);
      check("wlog_data", wlog_d[i], d);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 16'($urandom);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] w, input int gap, input bit st);
    int tries;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    start    = st;
    tries    = 0;
    while (in_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check("send_ready", in_ready, 1);
  endtask

  task automatic end_valid();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // gap < 0 selects a random 0..2 cycle gap per word.
  task automatic session(input logic [DW-1:0] hdr, input logic [DW-1:0] words[$],
                         input int gap, input bit bad_csum, input bit rnd_start);
    int            len;
    logic [DW-1:0] sum;
    logic [DW-1:0] cw;
    len = int'(hdr[AW:0]);
    sum = '0;
    pulse_start();
    send(hdr, 0, 1'b0);
    if (len >= 1 && len <= DEPTH) begin
      foreach (words[i]) begin
        send(words[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap,
             rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0);
        sum = sum + words[i];
      end
      cw = bad_csum ? sum + 16'd1 : sum;
`ifdef KARP_LOADER_CHECKSUM_EN
      send(cw, 0, 1'b0);
`endif
    end
    end_valid();
  endtask

  initial begin
    logic [DW-1:0] q[$];
    repeat (2) @(negedge clk);
    clr    = 1'b0;
    chk_en = 1'b1;
    check("reset_in_ready", in_ready, 0);
    check("reset_cpu_hold", cpu_hold, 0);
    check("reset_mem_we", mem_we, 0);

    // Basic load, valid held high.
    clear_log();
    q = '{16'h1111, 16'h2222, 16'h3333};
    session(16'd3, q, 0, 1'b0, 1'b0);
    check("basic_writes", wlog_a.size(), 3);
    check_write(0, 6'd0, 16'h1111);
    check_write(1, 6'd1, 16'h2222);
    check_write(2, 6'd2, 16'h3333);
    check("basic_done_cnt", done_cnt, 1);

    // Backpressure: four idle cycles between words.
    clear_log();
    q = '{16'hA5A5, 16'h5A5A};
    session(16'd2, q, 4, 1'b0, 1'b0);
    check("bp_writes", wlog_a.size(), 2);
    check_write(0, 6'd0, 16'hA5A5);
    check_write(1, 6'd1, 16'h5A5A);

    // Bad header then recovery via start.
    clear_log();
    q = {};
    session(16'd0, q, 0, 1'b0, 1'b0);
    check("badhdr_error", error, 1);
    check("badhdr_hold", cpu_hold, 1);
    check("badhdr_writes", wlog_a.size(), 0);
    q = '{16'hBEEF};
    session(16'd1, q, 0, 1'b0, 1'b0);
    check("recover_error", error, 0);
    check_write(0, 6'd0, 16'hBEEF);
    check("recover_done_cnt", done_cnt, 1);

    // Oversized header (65) is rejected.
    clear_log();
    q = {};
    session(16'd65, q, 0, 1'b0, 1'b0);
    check("len65_error", error, 1);

    // Full memory; valid kept high afterwards must not cause a 65th write.
    clear_log();
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(16'(i));
    session(16'd64, q, 0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_writes", wlog_a.size(), 64);
    check_write(63, 6'd63, 16'd63);
    check("full_done_cnt", done_cnt, 1);

    // Reset mid-load.
    clear_log();
    pulse_start();
    send(16'd5, 0, 1'b0);
    send(16'h0101, 0, 1'b0);
    send(16'h0202, 0, 1'b0);
    @(negedge clk);
    clr     = 1'b1;
    in_data = 16'h0303;
    @(negedge clk);
    clr = 1'b0;
    check("midclr_cpu_hold", cpu_hold, 0);
    check("midclr_in_ready", in_ready, 0);
    check("midclr_addr", addr_out, 0);
    repeat (4) begin
      @(negedge clk);
      in_data = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("midclr_writes", wlog_a.size(), 2);

`ifdef KARP_LOADER_CHECKSUM_EN
    clear_log();
    q = '{16'h0001, 16'hFFFF};
    session(16'd2, q, 0, 1'b0, 1'b0);
    check("csum_good_done", done_cnt, 1);
    check("csum_good_writes", wlog_a.size(), 2);
    clear_log();
    session(16'd2, q, 0, 1'b1, 1'b0);
    check("csum_bad_error", error, 1);
    check("csum_bad_writes", wlog_a.size(), 2);
    check("csum_bad_done", done_cnt, 0);
`endif

    // Randomized sessions: junk upper header bits, random gaps and starts.
    for (int s = 0; s < 25; s++) begin
      int            len;
      bit            badc;
      logic [DW-1:0] hdr;
      len  = int'($urandom_range(0, 70));
      hdr  = (16'($urandom) & 16'hFF80) | 16'(len);
      badc = ($urandom_range(0, 3) == 0);
      q    = {};
      if (len >= 1 && len <= DEPTH)
        for (int i = 0; i < len; i++) q.push_back(16'($urandom));
      session(hdr, q, -1, badc, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_loader
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer end of the processor's program-memory bus. It accepts a word stream from an external host, writes the words into program memory starting at address 0, and holds the processor in clear while it does so.
- Sits between the board input port and the memory address/data bus. When loading finishes, the processor's controller and PC take over the bus as readers.

Parameters:
- ADDR_W, 6, memory address width; memory depth is 2^ADDR_W words.
- DATA_W, 16, word width on the data bus and the input stream.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- in_data  input  DATA_W  host word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the word this cycle.
- addr_out  output  ADDR_W  memory write address.
- data_out  output  DATA_W  memory write data.
- mem_we  output  1  memory write strobe; addr_out and data_out are valid when high.
- cpu_hold  output  1  holds the PC, IR, MDR and controller in clear and tristates their bus drivers.
- done  output  1  one-cycle pulse when a load completes successfully.
- error  output  1  sticky load failure.

Behaviour:
- Reset is synchronous on clr: state=IDLE and every output is 0 (in_ready, addr_out, data_out, mem_we, cpu_hold, done, error). Internal count and addr registers are also 0.
- Handshake: a transfer occurs on any posedge where in_valid&in_ready=1. in_ready is a registered function of state only; it never depends on in_valid. The host may hold or drop valid freely.
- FSM states: IDLE, HDR, LOAD, CSUM (only with feature), DONE, ERR.
- IDLE: in_ready=0, cpu_hold=0. start=1 -> HDR. Setting cpu_hold=1 and error=0 both take effect from the next cycle.
- HDR: in_ready=1. On transfer, len = in_data[ADDR_W:0] and higher bits are ignored. If len==0 or len>2^ADDR_W -> ERR. Otherwise write pointer=0 and count=0 -> LOAD.
- LOAD: in_ready=1. A transfer at edge k registers addr_out=pointer, data_out=in_data and mem_we=1 for exactly the cycle after edge k, so memory samples them at edge k+1. The pointer then increments modulo 2^ADDR_W and count increments.
  - When count reaches len -> DONE, or -> CSUM when the feature is compiled in.
  - mem_we=0 on every cycle with no transfer.
  - Back-to-back transfers give back-to-back writes.
- DONE: for one cycle, done=1 and in_ready=0, then -> IDLE. cpu_hold falls at the IDLE entry edge, which is the same edge at which done falls.
- ERR: error=1, cpu_hold=1, in_ready=0. The state is left only by clr or by start (start -> HDR, clearing error).
- start is ignored in HDR, LOAD, CSUM and DONE.
- len=2^ADDR_W fills all of memory. The final write is to address 2^ADDR_W-1, and the pointer wraps to 0 without causing any further write.
- clr mid-session aborts immediately with no further writes. Memory contents already written are unspecified to the processor.
- The last LOAD write and DONE are ordered: mem_we for the final word is asserted in the same cycle the FSM enters DONE, so done is high in that cycle too.

Optional Feature:
- Macro: KARP_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A DATA_W accumulator clears in HDR and adds each LOAD data word modulo 2^DATA_W.
  - After the last data word, state CSUM has in_ready=1.
  - The next transferred word is compared with the accumulator: equal -> DONE; unequal -> ERR.
  - The checksum word is never written to memory.
- Without the macro: there is no CSUM state and no accumulator, and LOAD goes straight to DONE.

Decomposition:
- Shared package karpentium_pkg:
  - ADDR_W/DATA_W defaults (6/16).
  - Loader state enum: IDLE, HDR, LOAD, CSUM, DONE, ERR.
  - Constant MEM_DEPTH = 2^ADDR_W.
- One natural sub-module, loader_checksum: the accumulator with clear, add-enable and compare output. It is instantiated only under KARP_LOADER_CHECKSUM_EN.

Test Plan:
- Basic load: clr, start, header 3, then words 0x1111, 0x2222, 0x3333 with valid held high -> mem_we high for 3 consecutive cycles at addr 0,1,2 with the matching data. done pulses once, and cpu_hold is 1 from start+1 until done falls.
- Backpressure: header 2, with 4 idle cycles between valid words 0xA5A5 and 0x5A5A -> exactly 2 mem_we pulses at addr 0 and 1. in_ready stays 1 throughout LOAD.
- Bad header: header 0 -> error=1, cpu_hold=1, no mem_we. A start pulse then clears error, and header 1 with word 0xBEEF writes addr 0 and sets done.
- Full memory: header 64 with words 0..63 -> 64 writes, the final one at addr 63. done pulses once and there is no 65th write.
- Reset mid-load: header 5, two words accepted, clr for 1 cycle -> no further mem_we, all outputs 0, state IDLE. Further in_valid is ignored until start.
- Checksum (macro on): header 2, words 0x0001 and 0xFFFF, checksum 0x0000 -> done. Repeating with checksum 0x0001 -> error=1 and exactly 2 writes, with no checksum word written.
